// File: rtl/f_sqrt_arbiter.sv
// Round-robin front end that shares one iterative f_sqrt unit among N_REQ
// requesters, one operation in flight, with a watchdog on lost results.
module f_sqrt_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned FLEN    = 64,
  localparam int unsigned IDW    = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FLEN-1:0] req_a,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [FLEN-1:0]       res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_error,
  output logic                  res_timeout,
  output logic [FLEN-1:0]       sqrt_a,
  output logic [FLEN-1:0]       sqrt_b,
  output logic                  sqrt_up_valid,
  input  logic [FLEN-1:0]       sqrt_res,
  input  logic                  sqrt_down_valid,
  input  logic                  sqrt_busy,
  input  logic                  sqrt_error
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [FLEN-1:0] op_q;
  logic [WDW-1:0]  wd_q;
  logic            res_valid_q;
  logic [FLEN-1:0] res_data_q;
  logic            res_error_q;
  logic            res_timeout_q;

  logic [FLEN-1:0]  lane_c [N_REQ];
  logic [N_REQ-1:0] grant_c;
  logic [IDW-1:0]   win_c;
  logic [IDW-1:0]   idx_c;
  logic             found_c;

  // Unpack the flattened operand bus into per-requester lanes
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_c[i] = req_a[i*FLEN +: FLEN];
  end

  // Round-robin winner: first valid index searching upward from ptr+1
  always_comb begin
    grant_c = '0;
    win_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_c = IDW'((32'(ptr_q) + k) % N_REQ);
      if (!found_c && req_valid[idx_c]) begin
        found_c        = 1'b1;
        win_c          = idx_c;
        grant_c[idx_c] = 1'b1;
      end
    end
  end

  // Control FSM, watchdog counter and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(N_REQ - 1);
      id_q          <= '0;
      op_q          <= '0;
      wd_q          <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_error_q   <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_c) begin
            op_q    <= lane_c[win_c];
            id_q    <= win_c;
            ptr_q   <= win_c;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!sqrt_busy) begin
            wd_q    <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A real result wins over a simultaneous timeout
          if (sqrt_down_valid) begin
            res_data_q    <= sqrt_res;
            res_error_q   <= sqrt_error;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            res_data_q    <= '0;
            res_error_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and issue strobes are combinational from state and inputs
  assign req_ready     = (!rst && state_q == IDLE) ? grant_c : '0;
  assign sqrt_up_valid = !rst && (state_q == ISSUE) && !sqrt_busy;

  assign sqrt_a      = op_q;
  assign sqrt_b      = '0;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_id      = id_q;
  assign res_error   = res_error_q;
  assign res_timeout = res_timeout_q;

endmodule
